// File: rtl/mul_div_if.sv
// Request/response bundle between the datapath and mul_div_unit.
//   start  : request strobe, sampled when the unit is idle or done
//   op     : RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a, b   : rs1 / rs2 operands
//   busy   : operation in progress
//   done   : one-cycle result-valid pulse
//   result : result word, held until the next accepted start
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, a, b, input busy, done, result);
  modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. One bit per cycle: shift-add
// multiplication and restoring division on operand magnitudes, followed by a
// single sign-fix/select cycle.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of mul_div_if (start/op/a/b in, busy/done/result out)
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clock,
  input  logic     resetn,
  mul_div_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] mcand_q;   // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] hi_q;      // product high word / partial remainder
  logic [WIDTH-1:0] lo_q;      // multiplier -> product low word / dividend -> quotient
  logic             neg_q;     // product/quotient must be negated
  logic             rem_neg_q; // remainder takes the dividend's sign
  logic             dz_q;      // divisor was zero
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             signed_a;
  logic             signed_b;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] result_d;

  always_comb begin
    accept   = bus.start && (state_q == S_IDLE || state_q == S_DONE);
    signed_a = (bus.op == 3'b001) || (bus.op == 3'b010) ||
               (bus.op == 3'b100) || (bus.op == 3'b110);
    signed_b = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    a_neg    = signed_a && bus.a[WIDTH-1];
    b_neg    = signed_b && bus.b[WIDTH-1];
    a_mag    = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag    = b_neg ? (~bus.b + 1'b1) : bus.b;

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1
    // bits and bit WIDTH of the difference is a clean borrow flag.
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};

    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    // Division by zero keeps the all-ones quotient regardless of dividend sign.
    quo_fix  = (neg_q && !dz_q) ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = rem_neg_q ? (~hi_q + 1'b1) : hi_q;

    result_d = '0;
    case (op_q)
      3'b000:                 result_d = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result_d = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         result_d = quo_fix;
      default:                result_d = rem_fix;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q   <= S_CALC;
            cnt_q     <= '0;
            op_q      <= bus.op;
            hi_q      <= '0;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= (bus.b == '0);
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            if (bus.op[2]) begin
              mcand_q <= b_mag;
              lo_q    <= a_mag;
            end else begin
              mcand_q <= a_mag;
              lo_q    <= b_mag;
            end
          end else begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            if (!div_diff[WIDTH]) begin
              hi_q <= div_diff[WIDTH-1:0];
              lo_q <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              hi_q <= div_shift[WIDTH-1:0];
              lo_q <= {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIX: begin
          result_q <= result_d;
          state_q  <= S_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clock = ~clock;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // Drive one request; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done (bounded); busy_ok clears if busy dropped early.
  task automatic wait_done(output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = (bus.busy === 1'b1);
    while (cycles < 100) begin
      @(posedge clock);
      #1;
      cycles++;
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    resetn    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else pass_cnt++;
    total_cnt++;
    if (bus.result !== 32'h0) $display("FAIL reset_result got=%h exp=0", bus.result); else pass_cnt++;
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_mul();
    logic [2:0]  ops  [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] av   [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv   [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h2};
    logic [31:0] expv [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int cyc;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], bv[i]);
      wait_done(cyc, bok);
      total_cnt++;
      if (bus.result !== expv[i]) $display("FAIL mul_result[%0d] got=%h exp=%h", i, bus.result, expv[i]); else pass_cnt++;
      total_cnt++;
      if (cyc != 33) $display("FAIL mul_latency[%0d] got=%0d exp=33", i, cyc); else pass_cnt++;
      total_cnt++;
      if (!bok) $display("FAIL mul_busy_during[%0d] got=0 exp=1", i); else pass_cnt++;
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL mul_busy_at_done[%0d] got=%b exp=0", i, bus.busy); else pass_cnt++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] av   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bv   [4] = '{32'h2, 32'h2, 32'd7, 32'd7};
    logic [31:0] expv [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int cyc;
    bit bok;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], bv[i]);
      wait_done(cyc, bok);
      total_cnt++;
      if (bus.result !== expv[i]) $display("FAIL div_result[%0d] got=%h exp=%h", i, bus.result, expv[i]); else pass_cnt++;
      total_cnt++;
      if (cyc != 33) $display("FAIL div_latency[%0d] got=%0d exp=33", i, cyc); else pass_cnt++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_div_boundary();
    logic [2:0]  ops  [6] = '{3'b100, 3'b110, 3'b100, 3'b101, 3'b100, 3'b110};
    logic [31:0] av   [6] = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'd9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] expv [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    int cyc;
    bit bok;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], av[i], bv[i]);
      wait_done(cyc, bok);
      total_cnt++;
      if (bus.result !== expv[i]) $display("FAIL divb_result[%0d] got=%h exp=%h", i, bus.result, expv[i]); else pass_cnt++;
      total_cnt++;
      if (cyc != 33) $display("FAIL divb_latency[%0d] got=%0d exp=33", i, cyc); else pass_cnt++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    bit bok;
    issue(3'b101, 32'd100, 32'd7);
    repeat (5) @(posedge clock);
    #1;
    bus.op    = 3'b000;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_done(cyc, bok);
    total_cnt++;
    if (bus.result !== 32'd14) $display("FAIL ignore_result got=%h exp=%h", bus.result, 32'd14); else pass_cnt++;
    total_cnt++;
    if (cyc + 6 != 33) $display("FAIL ignore_latency got=%0d exp=33", cyc + 6); else pass_cnt++;
  endtask

  task automatic test_hold();
    // Unit sits in DONE with result 14 from the previous scenario.
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h1234_5678;
    repeat (5) @(posedge clock);
    #1;
    total_cnt++;
    if (bus.result !== 32'd14) $display("FAIL hold_result got=%h exp=%h", bus.result, 32'd14); else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL hold_done got=%b exp=0", bus.done); else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL hold_busy got=%b exp=0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit bok;
    issue(3'b111, 32'd100, 32'd7);
    wait_done(cyc, bok);
    total_cnt++;
    if (bus.result !== 32'd2) $display("FAIL b2b_first got=%h exp=%h", bus.result, 32'd2); else pass_cnt++;
    bus.op    = 3'b000;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL b2b_done_drop got=%b exp=0", bus.done); else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.result !== 32'd2) $display("FAIL b2b_held got=%h exp=%h", bus.result, 32'd2); else pass_cnt++;
    wait_done(cyc, bok);
    total_cnt++;
    if (bus.result !== 32'd42) $display("FAIL b2b_second got=%h exp=%h", bus.result, 32'd42); else pass_cnt++;
    total_cnt++;
    if (cyc != 33) $display("FAIL b2b_latency got=%0d exp=33", cyc); else pass_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit bok;
    bit seen_done;
    bit seen_busy;
    issue(3'b000, 32'd11, 32'd13);
    repeat (10) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL rmid_done got=%b exp=0", bus.done); else pass_cnt++;
    total_cnt++;
    if (bus.result !== 32'h0) $display("FAIL rmid_result got=%h exp=0", bus.result); else pass_cnt++;
    @(posedge clock);
    #3;
    resetn    = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.done === 1'b1) seen_done = 1'b1;
      if (bus.busy === 1'b1) seen_busy = 1'b1;
    end
    total_cnt++;
    if (seen_done) $display("FAIL rmid_no_done got=1 exp=0"); else pass_cnt++;
    total_cnt++;
    if (seen_busy) $display("FAIL rmid_no_busy got=1 exp=0"); else pass_cnt++;
    issue(3'b101, 32'd100, 32'd7);
    wait_done(cyc, bok);
    total_cnt++;
    if (bus.result !== 32'd14) $display("FAIL rmid_next got=%h exp=%h", bus.result, 32'd14); else pass_cnt++;
    total_cnt++;
    if (cyc != 33) $display("FAIL rmid_latency got=%0d exp=33", cyc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_boundary();
    test_ignore_start();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle iterative multiply/divide unit implementing RV32M for the single-cycle computer's datapath.
- Sits beside the combinational ALU on the same operand buses.
- The datapath issues a request with `start`; the unit answers with `busy`/`done` and a held `result`, so the core stalls until `done`.
- Shift-add multiplication and restoring division, one bit per cycle.

Parameters:
- WIDTH, 32, operand/result width and iteration count; only 32 is verified.

Ports:
- clock   input   1      rising-edge clock
- resetn  input   1      asynchronous active-low reset
- start   input   1      request; sampled on a rising edge when state is IDLE or DONE
- op      input   3      operation (funct3): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a       input   WIDTH  rs1 operand (multiplicand / dividend)
- b       input   WIDTH  rs2 operand (multiplier / divisor)
- busy    output  1      high while an operation is in progress
- done    output  1      one-cycle pulse: result valid
- result  output  WIDTH  result; held stable from `done` until the next accepted start

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE; busy = 0, done = 0, result = 0.
  - Iteration counter, operand and accumulator registers cleared.
  - Reset mid-operation aborts it; no `done` is produced.
- State machine:
  - States: IDLE, CALC, FIX, DONE.
  - IDLE/DONE -> CALC on an edge with start = 1.
  - DONE -> IDLE on an edge with start = 0.
  - CALC -> FIX after 32 iterations.
  - FIX -> DONE unconditionally.
- Acceptance (edge E0):
  - op, a and b are latched.
  - For signed ops, operand magnitudes are taken and the result sign is recorded:
    - MULH: both operands signed.
    - MULHSU: a signed, b unsigned.
    - DIV/REM: both operands signed.
  - Counter = 0.
- CALC: edges E1..E32, one iteration per edge.
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring; partial remainder 33 bits.
  - Counter increments and wraps 31 -> 0 on the transition to FIX.
- FIX: edge E33.
  - Applies sign correction and selects the low or high 32 bits (MUL low; MULH/MULHSU/MULHU high), or the quotient or remainder.
  - Writes `result`; state -> DONE.
- Outputs and latency:
  - busy = 1 in CALC and FIX (from after E0 through E33).
  - done = 1 only in DONE (between E33 and E34).
  - Latency is 33 cycles from the accepting edge to `done`.
- Start while busy is ignored; the latched operands are unaffected.
- Start while in DONE is accepted: back-to-back operation with no IDLE cycle; `done` drops on that edge.
- `result` changes only at FIX; it holds through DONE and IDLE.
- Boundary cases (RISC-V rules):
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = a. Still 33-cycle latency.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
  - Remainder sign follows the dividend; quotient truncates toward zero.
  - MUL low word is identical for signed/unsigned interpretation.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after the start edge, busy high for the 33 cycles before it.
- MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
- Divide by zero: DIV a=5, b=0 -> 0xFFFFFFFF; REM -> 5. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Handshake:
  - Start pulsed mid-CALC with different a/b: ignored, first result unchanged.
  - Start held high during DONE: second op accepted immediately, second done 33 cycles later.
  - Result holds between ops.
- Reset: resetn low for 1 cycle at iteration 10 -> busy, done and result = 0 immediately (asynchronously); no done pulse; the next start completes normally.
